// File: rtl/data_read_if.sv
// Bundle of the descriptor handshake, memory read port and AXI R channel used by data_read.
// slave is the engine's view; master is the view of the address stage, memory and R master.
interface data_read_if #(
  parameter int ADD_ID_WIDTH = 4,
  parameter int ADD_WIDTH    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int BURST_SIZE   = 3,
  parameter int BURST_TYPE   = 2
) ();
  logic                    mod1_valid_in;
  logic                    mod1_ready_out;
  logic [ADD_WIDTH-1:0]    addr_in;
  logic [ADD_ID_WIDTH-1:0] id_in;
  logic [BURST_LEN-1:0]    burst_length_in;
  logic [BURST_SIZE-1:0]   burst_size_in;
  logic [BURST_TYPE-1:0]   burst_type_in;
  logic                    mem_en;
  logic [ADD_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [ADD_ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  mod1_valid_in, addr_in, id_in, burst_length_in, burst_size_in, burst_type_in,
    input  mem_rdata, rready,
    output mod1_ready_out, mem_en, mem_addr, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output mod1_valid_in, addr_in, id_in, burst_length_in, burst_size_in, burst_type_in,
    output mem_rdata, rready,
    input  mod1_ready_out, mem_en, mem_addr, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/data_read.sv
// AXI slave read-data engine: walks one burst descriptor at a time through a
// single-cycle-latency memory port and presents the beats on the R channel.
//
// state | meaning (derived from beats_left and rvalid, no separate state register)
// IDLE  | beats_left == 0, R empty; descriptor accepted
// BURST | beats_left  > 0, reads issue whenever R is free or being accepted
// DRAIN | beats_left == 0, final beat still on R; next descriptor already accepted
module data_read #(
  parameter int ADD_ID_WIDTH = 4,
  parameter int ADD_WIDTH    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int BURST_SIZE   = 3,
  parameter int BURST_TYPE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_read_if.slave bus
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int LANE_BITS  = $clog2(DATA_BYTES);
  localparam int BL1        = BURST_LEN + 1;

  logic [BURST_LEN:0]      beats_left;
  logic [ADD_WIDTH-1:0]    cur_addr;
  logic [ADD_WIDTH-1:0]    step_q;
  logic [ADD_WIDTH-1:0]    wrap_lo;
  logic [ADD_WIDTH:0]      wrap_hi;
  logic                    wrap_q;
  logic                    fixed_q;
  logic                    err_q;
  logic [ADD_ID_WIDTH-1:0] id_q;

  logic                    fresh;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rvalid_q;
  logic [ADD_ID_WIDTH-1:0] rid_q;
  logic                    rlast_q;
  logic [1:0]              rresp_q;

  logic                    accept;
  logic                    issue;
  logic                    size_ok;
  logic [BURST_SIZE-1:0]   acc_shift;
  logic [BURST_LEN:0]      acc_beats;
  logic [ADD_WIDTH-1:0]    acc_span;
  logic [ADD_WIDTH-1:0]    acc_lo;
  logic                    acc_wrap;
  logic                    acc_err;
  logic [ADD_WIDTH:0]      inc_addr;
  logic [ADD_WIDTH-1:0]    next_addr;

  assign accept = bus.mod1_valid_in && (beats_left == '0);
  assign issue  = (beats_left != '0) && (!rvalid_q || bus.rready);

  // Oversized beats fall back to a full data-word step and are flagged SLVERR.
  always_comb begin
    size_ok   = bus.burst_size_in <= BURST_SIZE'(LANE_BITS);
    acc_shift = size_ok ? bus.burst_size_in : BURST_SIZE'(LANE_BITS);
    acc_beats = {1'b0, bus.burst_length_in} + 1'b1;
    acc_span  = ADD_WIDTH'(acc_beats) << acc_shift;
    acc_lo    = bus.addr_in & ~(acc_span - 1'b1);
    acc_wrap  = (bus.burst_type_in == BURST_TYPE'(2)) &&
                ((acc_beats == BL1'(2)) || (acc_beats == BL1'(4)) ||
                 (acc_beats == BL1'(8)) || (acc_beats == BL1'(16)));
    acc_err   = !size_ok || (bus.burst_type_in == BURST_TYPE'(3));
  end

  always_comb begin
    inc_addr  = {1'b0, cur_addr} + {1'b0, step_q};
    next_addr = inc_addr[ADD_WIDTH-1:0];
    if (fixed_q)
      next_addr = cur_addr;
    else if (wrap_q && (inc_addr >= wrap_hi))
      next_addr = wrap_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beats_left <= '0;
      cur_addr   <= '0;
      step_q     <= '0;
      wrap_lo    <= '0;
      wrap_hi    <= '0;
      wrap_q     <= 1'b0;
      fixed_q    <= 1'b0;
      err_q      <= 1'b0;
      id_q       <= '0;
      fresh      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
    end else begin
      fresh <= issue;
      if (fresh)
        rdata_q <= bus.mem_rdata;

      if (accept) begin
        beats_left <= acc_beats;
        cur_addr   <= bus.addr_in;
        step_q     <= ADD_WIDTH'(1) << acc_shift;
        wrap_lo    <= acc_lo;
        wrap_hi    <= {1'b0, acc_lo} + {1'b0, acc_span};
        wrap_q     <= acc_wrap;
        fixed_q    <= bus.burst_type_in == BURST_TYPE'(0);
        err_q      <= acc_err;
        id_q       <= bus.id_in;
      end else if (issue) begin
        beats_left <= beats_left - 1'b1;
        cur_addr   <= next_addr;
      end

      // Beat attributes ride with the issue so a new descriptor cannot disturb them.
      if (issue) begin
        rvalid_q <= 1'b1;
        rid_q    <= id_q;
        rlast_q  <= beats_left == BL1'(1);
        rresp_q  <= err_q ? 2'b10 : 2'b00;
      end else if (bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.mod1_ready_out = beats_left == '0;
  assign bus.mem_en         = issue;
  assign bus.mem_addr       = cur_addr & ~ADD_WIDTH'(DATA_BYTES - 1);
  // Memory data arrives one cycle after the strobe; hold a copy for stalled beats.
  assign bus.rdata          = fresh ? bus.mem_rdata : rdata_q;
  assign bus.rvalid         = rvalid_q;
  assign bus.rid            = rid_q;
  assign bus.rlast          = rlast_q;
  assign bus.rresp          = rresp_q;
endmodule

// File: doc/data_read.md
# data_read

AXI memory-slave read-data engine. It accepts one read burst descriptor at a time from the read-address stage, fetches each beat from the slave memory over a single-cycle-latency read port, and drives the AXI R channel (rid/rdata/rresp/rlast/rvalid). It is the read-direction counterpart of the slave's write-data path and shares the same descriptor handshake with the address stage.

## Interface
- ADD_ID_WIDTH, 4: width of the AXI ID field.
- ADD_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: R data width, a power of two that is at least 8.
- BURST_LEN, 4: width of the burst-length field; beats = value + 1.
- BURST_SIZE, 3: width of the burst-size field; bytes per beat = 2^value.
- BURST_TYPE, 2: width of the burst-type field; 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- mod1_valid_in  in  1  the address stage presents a descriptor.
- mod1_ready_out  out  1  this block accepts the descriptor this cycle.
- addr_in  in  ADD_WIDTH  start byte address.
- id_in  in  ADD_ID_WIDTH  burst ID.
- burst_length_in  in  BURST_LEN  beats minus 1.
- burst_size_in  in  BURST_SIZE  log2 of bytes per beat.
- burst_type_in  in  BURST_TYPE  burst type.
- mem_en  out  1  memory read strobe.
- mem_addr  out  ADD_WIDTH  word-aligned read address; the low log2(DATA_WIDTH/8) bits are 0.
- mem_rdata  in  DATA_WIDTH  memory word; valid the cycle after mem_en.
- rid  out  ADD_ID_WIDTH  R beat ID.
- rdata  out  DATA_WIDTH  R beat data; the full word at the aligned address (narrow transfers use the byte lanes selected by the address).
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  final beat of the burst.
- rvalid  out  1  R beat valid.
- rready  in  1  the master accepts the beat.

## Operation
- **Issue-side state.**
  - cur_addr (ADD_WIDTH bits) and beats_left (BURST_LEN+1 bits).
  - Latched id, size, type, error flag, and the wrap bounds.
- **Output register.** Holds rvalid, rid, rdata, rresp and rlast.
  - rid, rresp and rlast are captured at issue time and travel with the beat.
  - A new descriptor therefore never corrupts a beat still held on R.
- **States** (derived from beats_left and rvalid):
  - IDLE: beats_left=0 and !rvalid.
  - BURST: beats_left>0.
  - DRAIN: beats_left=0 and rvalid.
- **mod1_ready_out** = (beats_left==0). It is combinational and high in IDLE and DRAIN. On accept, all descriptor fields are latched and beats_left = burst_length_in+1.
- **Issue rule.** mem_en = (beats_left>0) && (!rvalid || rready). This depends combinationally on rready.
- **On issue:**
  - mem_addr = cur_addr with the low bits cleared.
  - beats_left decrements.
  - The pipe tag is captured: id; last = (beats_left==1); resp.
  - cur_addr advances according to the burst type.
- **Address advance:**
  - FIXED: unchanged.
  - INCR: cur_addr + 2^size, modulo 2^ADD_WIDTH.
  - WRAP: len_bytes = (len+1)<<size; lower = cur_addr with the low log2(len_bytes) bits cleared. When the next address reaches lower+len_bytes, it returns to lower.
  - WRAP with a beat count other than 2, 4, 8 or 16 is treated as INCR.
- **Output-register load.** The cycle after an issue: rvalid=1, rdata=mem_rdata, and rid/rlast/rresp come from the pipe tag.
- **Output-register clear.** If rvalid && rready and no issue occurred in the previous cycle, rvalid clears.
- **Errors.** SLVERR (rresp=10) on every beat of a burst when:
  - burst_type=11; the addresses then advance as INCR.
  - or 2^size > DATA_WIDTH/8; the address then advances by DATA_WIDTH/8.
  
  Data is still fetched and returned in both cases. All other bursts return rresp=00.
- **Stability.** The R outputs stay stable while rvalid && !rready.

## Timing
- **Reset values:** mod1_ready_out=1 (beats_left=0), mem_en=0, mem_addr=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=00.
- **Reset mid-burst:** the next cycle has rvalid=0 and beats_left=0. Any in-flight mem_rdata is discarded and no further mem_en is issued.
- **Latency:** descriptor accepted at cycle t → first mem_en at t+1 → first rvalid at t+2.
- **Throughput:** one beat per cycle while rready=1.
- **Back-to-back bursts:** the final issue of burst A occurs at t; B is accepted at t+1 and issued at t+2. There is exactly one idle R cycle between A's rlast and B's first beat when rready is held high.
- **rready low:** rvalid and the data hold, and no issue occurs. Issue resumes in the cycle rready returns high.
- **Single-beat burst (len=0):** the first beat carries rlast=1.

## Test plan
- **Single-beat read.** Reset, then addr=0x10, id=3, len=0, size=2, INCR. Required: mem_addr=0x10 at t+1; rvalid, rid=3, rlast=1, rresp=00 at t+2.
- **INCR burst with backpressure.** len=3, size=2, addr=0x20, rready pattern 1,0,0,1,1,1. Required: mem_addr sequence 0x20, 0x24, 0x28, 0x2C with no mem_en while rready=0; data and rlast on the 4th beat only; R outputs stable while stalled.
- **WRAP burst.** len=3, size=2, addr=0x38. Required: mem_addr sequence 0x38, 0x3C, 0x30, 0x34.
- **FIXED burst.** len=3 at 0x40 → four reads of 0x40.
- **Reserved type.** type=11, len=1 at 0x0 → addresses 0x0, 0x4 with rresp=10 on both beats.
- **Back-to-back bursts and reset.** Bursts A (id=1, len=1) and B (id=2, len=0) with rready=1. Required: B accepted the cycle after A's last issue; rid changes only with the beat; one idle R cycle between bursts. Then assert reset during a 16-beat burst. Required: rvalid=0 and mod1_ready_out=1 on the next cycle, and no further mem_en.
